// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Multi-cycle RV32M multiply/divide execute unit. Runs one
//            MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU at a time, holds the
//            pipeline through stall_req_o while iterating, then gives one
//            ALU-style write-back beat.
// Ports    : clk, rst (async, active-low)
//            start_i, op_i[2:0], r1_data_i, r2_data_i, w_addr_i, flush_i
//            stall_req_o, w_enable_o, w_addr_o[4:0], w_data_o[XLEN-1:0]
// Config   : MULDIV_FAST_MUL_EN - single-cycle combinational multiplies;
//            divides stay iterative.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] r1_data_i,
  input  logic [XLEN-1:0] r2_data_i,
  input  logic [4:0]      w_addr_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            w_enable_o,
  output logic [4:0]      w_addr_o,
  output logic [XLEN-1:0] w_data_o
);

  localparam int              N        = XLEN / BITS_PER_CYCLE;
  localparam int              CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;      // {hi, lo}: {partial product, multiplier} or {remainder, quotient}
  logic              neg_res_q;  // negate product / quotient
  logic              neg_rem_q;  // negate remainder
  logic [4:0]        w_addr_q;
  logic [XLEN-1:0]   w_data_q;

  // Apply the deferred result sign and pick the requested half.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0]        op,
                                               input logic [2*XLEN-1:0] acc,
                                               input logic              neg_res,
                                               input logic              neg_rem);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   r;
    logic [XLEN-1:0]   res;
    prod = neg_res ? -acc : acc;
    q    = acc[XLEN-1:0];
    r    = acc[2*XLEN-1:XLEN];
    case (op)
      3'd0:             res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res = neg_res ? -q : q;
      default:          res = neg_rem ? -r : r;
    endcase
    return res;
  endfunction

  // ---------------- operand decode at start ----------------
  logic            is_div;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            skip_busy;
  logic [XLEN-1:0] skip_res;

  always_comb begin
    is_div   = op_i[2];
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    a_neg    = r1_data_i[XLEN-1] &
               ((op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6));
    b_neg    = r2_data_i[XLEN-1] &
               ((op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6));
    a_mag    = a_neg ? -r1_data_i : r1_data_i;
    b_mag    = b_neg ? -r2_data_i : r2_data_i;
    div_zero = is_div & (r2_data_i == '0);
    div_ovf  = is_div & ~op_i[0] & (r1_data_i == SMIN) & (r2_data_i == '1);
    skip_busy = div_zero | div_ovf;
    if (div_zero)
      skip_res = op_i[1] ? r1_data_i : '1;
    else
      skip_res = op_i[1] ? '0 : r1_data_i;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div) begin
      skip_busy = 1'b1;
      skip_res  = finalize(op_i, {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag},
                           a_neg ^ b_neg, 1'b0);
    end
`endif
  end

  // ---------------- one iteration: BITS_PER_CYCLE sub-steps ----------------
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shl;
  logic [XLEN:0]     diff;

  always_comb begin
    acc_d = acc_q;
    sum   = '0;
    shl   = '0;
    diff  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        // restoring divide: shift next dividend bit into the remainder and
        // keep the subtraction only when it does not go negative
        shl  = {acc_d[2*XLEN-1:XLEN], acc_d[XLEN-1]};
        diff = shl - {1'b0, opnd_q};
        if (!diff[XLEN])
          acc_d = {diff[XLEN-1:0], acc_d[XLEN-2:0], 1'b1};
        else
          acc_d = {shl[XLEN-1:0], acc_d[XLEN-2:0], 1'b0};
      end else begin
        // shift-add multiply: multiplier sits in the low half and drains out
        sum   = {1'b0, acc_d[2*XLEN-1:XLEN]} + (acc_d[0] ? {1'b0, opnd_q} : '0);
        acc_d = {sum, acc_d[XLEN-1:1]};
      end
    end
  end

  // ---------------- control and state ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q      <= op_i;
            w_addr_q  <= w_addr_i;
            cnt_q     <= CNT_LOAD;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            opnd_q    <= is_div ? b_mag : a_mag;
            acc_q     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            if (skip_busy) begin
              w_data_q <= skip_res;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              w_data_q <= finalize(op_q, acc_d, neg_res_q, neg_rem_q);
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall covers the requesting cycle, so it must see start_i directly.
  assign stall_req_o = ((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_BUSY);
  // A flush landing on the DONE cycle kills the write-back of that same cycle.
  assign w_enable_o  = (state_q == S_DONE) & ~flush_i;
  assign w_addr_o    = w_addr_q;
  assign w_data_o    = w_data_q;

endmodule
`default_nettype wire
